// File: rtl/cpu_seq.sv
// Fetch/execute sequencer for the 4-bit CPU: owns PC, latches IR, decodes, steps IDLE/FETCH/EXEC/WAIT/HALT.
// Optional single-step WAIT state is built only when CPU_SEQ_STEP_EN is defined.
module cpu_seq (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STEP_MODE,
    input  logic       STEP,
    input  logic [8:0] INS,
    output logic [3:0] PC,
    output logic [2:0] OP,
    output logic [1:0] RD,
    output logic [1:0] RA,
    output logic [1:0] RB,
    output logic [3:0] IMM,
    output logic       WE,
    output logic       BUSY,
    output logic       HALTED,
    output logic       ERR,
    output logic [7:0] ICNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [8:0] ir_q, ir_d;
    logic       err_q, err_d;
    logic [7:0] icnt_q, icnt_d;
    logic [2:0] op;

    assign op = ir_q[8:6];

`ifndef CPU_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = STEP_MODE ^ STEP;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        icnt_d  = icnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (START) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    icnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = INS;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Opcodes 1xx stop the machine with PC left on the offending instruction.
                if (op[2]) begin
                    state_d = S_HALT;
                    if (op != 3'b100) err_d = 1'b1;
                end else begin
                    pc_d = pc_q + 4'd1;
                    if (icnt_q != 8'hFF) icnt_d = icnt_q + 8'd1;
`ifdef CPU_SEQ_STEP_EN
                    state_d = STEP_MODE ? S_WAIT : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_WAIT: begin
`ifdef CPU_SEQ_STEP_EN
                if (STEP || !STEP_MODE) state_d = S_FETCH;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        WE     = 1'b0;
        BUSY   = 1'b0;
        HALTED = 1'b0;
        case (state_q)
            S_FETCH: BUSY = 1'b1;
            S_EXEC: begin
                BUSY = 1'b1;
                WE   = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
            end
            S_WAIT:  BUSY   = 1'b1;
            S_HALT:  HALTED = 1'b1;
            default: ;
        endcase
    end

    assign PC   = pc_q;
    assign OP   = op;
    assign RD   = ir_q[5:4];
    assign RA   = ir_q[3:2];
    assign RB   = ir_q[1:0];
    assign IMM  = ir_q[3:0];
    assign ERR  = err_q;
    assign ICNT = icnt_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed self-checking bench for cpu_seq; models ins_mem as a combinational program array.
module tb_cpu_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       STEP_MODE = 1'b0;
    logic       STEP = 1'b0;
    logic [8:0] INS;
    logic [3:0] PC;
    logic [2:0] OP;
    logic [1:0] RD, RA, RB;
    logic [3:0] IMM;
    logic       WE, BUSY, HALTED, ERR;
    logic [7:0] ICNT;

    logic [8:0] prog [16];
    int         total = 0;
    int         bad = 0;

    assign INS = prog[PC];

    always #5 CLK = ~CLK;

    cpu_seq dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STEP_MODE(STEP_MODE), .STEP(STEP),
        .INS(INS), .PC(PC), .OP(OP), .RD(RD), .RA(RA), .RB(RB), .IMM(IMM),
        .WE(WE), .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR), .ICNT(ICNT)
    );

    task load_program;
        for (int i = 0; i < 16; i++) prog[i] = 9'b011_000000;
        prog[0] = 9'b000_01_10_11;
        prog[1] = 9'b001_10_01_00;
        prog[2] = 9'b010_11_0101;
        prog[3] = 9'b011_000000;
        prog[4] = 9'b000_00_11_10;
        prog[5] = 9'b001_01_00_01;
        prog[6] = 9'b010_10_1010;
        prog[7] = 9'b010_00_1111;
        prog[8] = 9'b100_000000;
    endtask

    task do_reset;
        START = 1'b0; STEP = 1'b0; STEP_MODE = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task test_reset;
        // {PC,WE,BUSY,HALTED,ERR,ICNT,OP}
        load_program;
        RST_N = 1'b0;
        #1;
        total++;
        if ({PC, WE, BUSY, HALTED, ERR, ICNT, OP} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0}) begin
            bad++;
            $display("FAIL reset_initial: got %h want %h", {PC, WE, BUSY, HALTED, ERR, ICNT, OP},
                     {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        total++;
        if ({PC, WE, BUSY, ICNT} !== {4'd2, 1'b1, 1'b1, 8'd2}) begin
            bad++;
            $display("FAIL reset_pre_exec: got PC=%0d WE=%b BUSY=%b ICNT=%0d want PC=2 WE=1 BUSY=1 ICNT=2",
                     PC, WE, BUSY, ICNT);
        end
        #2 RST_N = 1'b0;
        #1;
        total++;
        if ({PC, WE, BUSY, HALTED, ERR, ICNT, OP} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0}) begin
            bad++;
            $display("FAIL reset_mid_exec: got %h want %h", {PC, WE, BUSY, HALTED, ERR, ICNT, OP},
                     {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0});
        end
        @(negedge CLK);
        total++;
        if ({WE, BUSY} !== 2'b00) begin
            bad++;
            $display("FAIL reset_held: got WE=%b BUSY=%b want 0 0", WE, BUSY);
        end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task test_program;
        logic exp_we;
        load_program;
        do_reset;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            total++;
            if ({PC, BUSY, WE, ICNT} !== {i[3:0], 1'b1, 1'b0, i[7:0]}) begin
                bad++;
                $display("FAIL prog_fetch%0d: got PC=%0d BUSY=%b WE=%b ICNT=%0d want PC=%0d BUSY=1 WE=0 ICNT=%0d",
                         i, PC, BUSY, WE, ICNT, i, i);
            end
            @(negedge CLK);
            exp_we = (i != 3) && (i != 8);
            total++;
            if ({WE, OP, PC} !== {exp_we, prog[i][8:6], i[3:0]}) begin
                bad++;
                $display("FAIL prog_exec%0d: got WE=%b OP=%0d PC=%0d want WE=%b OP=%0d PC=%0d",
                         i, WE, OP, PC, exp_we, prog[i][8:6], i);
            end
            @(negedge CLK);
        end
        total++;
        if ({HALTED, BUSY, PC, ICNT, ERR, WE} !== {1'b1, 1'b0, 4'd8, 8'd8, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL prog_halt: got HALTED=%b BUSY=%b PC=%0d ICNT=%0d ERR=%b WE=%b want 1 0 8 8 0 0",
                     HALTED, BUSY, PC, ICNT, ERR, WE);
        end
        @(negedge CLK);
        total++;
        if ({HALTED, PC} !== {1'b1, 4'd8}) begin
            bad++;
            $display("FAIL prog_halt_hold: got HALTED=%b PC=%0d want 1 8", HALTED, PC);
        end
    endtask

    task test_illegal;
        load_program;
        prog[0] = 9'b111111110;
        do_reset;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        total++;
        if ({WE, BUSY, OP} !== {1'b0, 1'b1, 3'b111}) begin
            bad++;
            $display("FAIL illegal_exec: got WE=%b BUSY=%b OP=%0d want 0 1 7", WE, BUSY, OP);
        end
        @(negedge CLK);
        total++;
        if ({HALTED, ERR, PC, ICNT, WE, BUSY} !== {1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL illegal_halt: got HALTED=%b ERR=%b PC=%0d ICNT=%0d WE=%b BUSY=%b want 1 1 0 0 0 0",
                     HALTED, ERR, PC, ICNT, WE, BUSY);
        end
    endtask

    // Continues from the illegal-opcode halt with ERR set.
    task test_restart;
        load_program;
        START = 1'b1;
        @(negedge CLK);
        total++;
        if ({ERR, HALTED, BUSY, PC, ICNT} !== {1'b0, 1'b0, 1'b1, 4'd0, 8'd0}) begin
            bad++;
            $display("FAIL restart_err: got ERR=%b HALTED=%b BUSY=%b PC=%0d ICNT=%0d want 0 0 1 0 0",
                     ERR, HALTED, BUSY, PC, ICNT);
        end
        @(negedge CLK);
        total++;
        if ({WE, OP, PC} !== {1'b1, 3'b000, 4'd0}) begin
            bad++;
            $display("FAIL restart_exec: got WE=%b OP=%0d PC=%0d want 1 0 0", WE, OP, PC);
        end
        @(negedge CLK);
        START = 1'b0;
        total++;
        if ({PC, ICNT, BUSY} !== {4'd1, 8'd1, 1'b1}) begin
            bad++;
            $display("FAIL restart_start_ignored: got PC=%0d ICNT=%0d BUSY=%b want 1 1 1", PC, ICNT, BUSY);
        end
        repeat (16) @(negedge CLK);
        total++;
        if ({HALTED, ICNT, PC} !== {1'b1, 8'd8, 4'd8}) begin
            bad++;
            $display("FAIL restart_run_halt: got HALTED=%b ICNT=%0d PC=%0d want 1 8 8", HALTED, ICNT, PC);
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        total++;
        if ({ICNT, PC, BUSY, HALTED} !== {8'd0, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL restart_from_halt: got ICNT=%0d PC=%0d BUSY=%b HALTED=%b want 0 0 1 0",
                     ICNT, PC, BUSY, HALTED);
        end
        do_reset;
    endtask

    task test_wrap_saturate;
        int exp_cnt;
        for (int i = 0; i < 16; i++) prog[i] = 9'b011_000000;
        do_reset;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            exp_cnt = (i > 255) ? 255 : i;
            total++;
            if ({PC, ICNT, BUSY} !== {i[3:0], exp_cnt[7:0], 1'b1}) begin
                bad++;
                $display("FAIL wrap_sat%0d: got PC=%0d ICNT=%0d BUSY=%b want PC=%0d ICNT=%0d BUSY=1",
                         i, PC, ICNT, BUSY, i % 16, exp_cnt);
            end
            repeat (2) @(negedge CLK);
        end
        do_reset;
    endtask

`ifdef CPU_SEQ_STEP_EN
    task test_step;
        load_program;
        do_reset;
        STEP_MODE = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({PC, BUSY, WE, ICNT} !== {4'd1, 1'b1, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL step_wait0: got PC=%0d BUSY=%b WE=%b ICNT=%0d want 1 1 0 1", PC, BUSY, WE, ICNT);
        end
        repeat (3) @(negedge CLK);
        total++;
        if ({PC, OP, WE, ICNT} !== {4'd1, 3'b000, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL step_stall: got PC=%0d OP=%0d WE=%b ICNT=%0d want 1 0 0 1", PC, OP, WE, ICNT);
        end
        STEP = 1'b1;
        @(negedge CLK);
        STEP = 1'b0;
        @(negedge CLK);
        total++;
        if ({WE, OP, PC} !== {1'b1, 3'b001, 4'd1}) begin
            bad++;
            $display("FAIL step_exec1: got WE=%b OP=%0d PC=%0d want 1 1 1", WE, OP, PC);
        end
        repeat (2) @(negedge CLK);
        total++;
        if ({PC, ICNT, OP, WE} !== {4'd2, 8'd2, 3'b001, 1'b0}) begin
            bad++;
            $display("FAIL step_wait1: got PC=%0d ICNT=%0d OP=%0d WE=%b want 2 2 1 0", PC, ICNT, OP, WE);
        end
        STEP_MODE = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({OP, WE, PC} !== {3'b010, 1'b1, 4'd2}) begin
            bad++;
            $display("FAIL step_resume2: got OP=%0d WE=%b PC=%0d want 2 1 2", OP, WE, PC);
        end
        repeat (2) @(negedge CLK);
        total++;
        if ({OP, PC, ICNT} !== {3'b011, 4'd3, 8'd3}) begin
            bad++;
            $display("FAIL step_freerun: got OP=%0d PC=%0d ICNT=%0d want 3 3 3", OP, PC, ICNT);
        end
        do_reset;
    endtask
`else
    task test_step_ignored;
        load_program;
        do_reset;
        STEP_MODE = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({OP, PC, WE} !== {3'b001, 4'd1, 1'b1}) begin
            bad++;
            $display("FAIL step_ignored: got OP=%0d PC=%0d WE=%b want 1 1 1", OP, PC, WE);
        end
        do_reset;
    endtask
`endif

    initial begin
        test_reset;
        test_program;
        test_illegal;
        test_restart;
        test_wrap_saturate;
`ifdef CPU_SEQ_STEP_EN
        test_step;
`else
        test_step_ignored;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "timeout");
    end

endmodule
